// File: rtl/led_driver_sequencer_if.sv
// Bit-serial column data handshake between the frame source and the LED sequencer.
interface led_driver_sequencer_if;
  logic bit_valid;
  logic bit_data;
  logic bit_ready;

  modport master (output bit_valid, output bit_data, input bit_ready);
  modport slave  (input bit_valid, input bit_data, output bit_ready);
endinterface

// File: rtl/led_driver_sequencer.sv
// Sequencer for one daisy-chained grayscale LED driver string: gated SCLK/SIN shifting,
// counted GCLK grayscale periods, and BLANK/XLAT period closing.
module led_driver_sequencer #(
  parameter int SCLK_FACTOR  = 8,
  parameter int GCLK_FACTOR  = 4,
  parameter int GS_STEPS     = 4096,
  parameter int SHIFT_BITS   = 192,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  led_driver_sequencer_if.slave   bus,
  output logic                    SCLK,
  output logic                    SIN,
  output logic                    GCLK,
  output logic                    BLANK,
  output logic                    XLAT,
  output logic                    frame_done,
  output logic                    underrun
);
  localparam int HS = SCLK_FACTOR / 2;
  localparam int HG = GCLK_FACTOR / 2;
  localparam int PW = $clog2(SCLK_FACTOR);
  localparam int HW = $clog2(GCLK_FACTOR);
  localparam int EW = $clog2(GS_STEPS + 1);
  localparam int CW = $clog2(SHIFT_BITS + 1);
  localparam int BW = $clog2(BLANK_CYCLES);

  localparam logic [PW-1:0] PH_RISE   = PW'(HS - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(SCLK_FACTOR - 1);
  localparam logic [HW-1:0] HC_LAST   = HW'(HG - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(GS_STEPS);
  localparam logic [CW-1:0] BITS_LAST = CW'(SHIFT_BITS);
  localparam logic [BW-1:0] BC_LAST   = BW'(BLANK_CYCLES - 1);

  typedef enum logic {GS_RUN, GS_BLANK} gs_state_t;
  typedef enum logic {SH_SHIFT, SH_LOADED} sh_state_t;

  gs_state_t       gs_state_r, gs_next_s;
  sh_state_t       sh_state_r, sh_next_s;
  logic [HW-1:0]   hcnt_r, hcnt_next_s;
  logic [EW-1:0]   edges_r, edges_next_s;
  logic [BW-1:0]   bcnt_r, bcnt_next_s;
  logic [PW-1:0]   ph_r, ph_next_s;
  logic [CW-1:0]   bits_r, bits_next_s;
  logic            sclk_r, sclk_next_s, sin_r, sin_next_s, ready_r, ready_next_s;
  logic            gclk_r, gclk_next_s, blank_r, blank_next_s, xlat_r, xlat_next_s;
  logic            done_r, done_next_s, under_r, under_next_s;

  // Shift FSM: one bit per SCLK period, ph_r == 0 means idle/waiting for a transfer.
  always_comb begin
    sh_next_s    = sh_state_r;
    ph_next_s    = ph_r;
    bits_next_s  = bits_r;
    sin_next_s   = sin_r;
    sclk_next_s  = sclk_r;
    ready_next_s = ready_r;
    case (sh_state_r)
      SH_SHIFT: begin
        if (ph_r == '0) begin
          if (ready_r && bus.bit_valid) begin
            ready_next_s = 1'b0;
            sin_next_s   = bus.bit_data;
            ph_next_s    = PW'(1);
            bits_next_s  = bits_r + CW'(1);
          end else begin
            ready_next_s = 1'b1;
          end
        end else if (ph_r == PH_LAST) begin
          ph_next_s   = '0;
          sclk_next_s = 1'b0;
          if (bits_r == BITS_LAST) begin
            sh_next_s    = SH_LOADED;
            ready_next_s = 1'b0;
          end else begin
            ready_next_s = 1'b1;
          end
        end else begin
          ph_next_s = ph_r + PW'(1);
          if (ph_r == PH_RISE) begin
            sclk_next_s = 1'b1;
          end else begin
            sclk_next_s = sclk_r;
          end
        end
      end
      SH_LOADED: begin
        sclk_next_s = 1'b0;
        ph_next_s   = '0;
        if (xlat_r) begin
          sh_next_s    = SH_SHIFT;
          bits_next_s  = '0;
          ready_next_s = 1'b1;
        end else begin
          ready_next_s = 1'b0;
        end
      end
      default: begin
        sh_next_s    = SH_SHIFT;
        ph_next_s    = '0;
        bits_next_s  = '0;
        sclk_next_s  = 1'b0;
        ready_next_s = 1'b0;
      end
    endcase
  end

  // Grayscale FSM: counted GCLK edges during RUN, fixed-length BLANK window with latch slot.
  always_comb begin
    gs_next_s    = gs_state_r;
    hcnt_next_s  = hcnt_r;
    edges_next_s = edges_r;
    bcnt_next_s  = bcnt_r;
    gclk_next_s  = gclk_r;
    blank_next_s = blank_r;
    xlat_next_s  = 1'b0;
    done_next_s  = 1'b0;
    under_next_s = 1'b0;
    case (gs_state_r)
      GS_RUN: begin
        if (hcnt_r == HC_LAST) begin
          hcnt_next_s = '0;
          if (!gclk_r) begin
            gclk_next_s  = 1'b1;
            edges_next_s = edges_r + EW'(1);
          end else if (edges_r == EDGE_LAST) begin
            gs_next_s    = GS_BLANK;
            bcnt_next_s  = '0;
            gclk_next_s  = 1'b0;
            blank_next_s = 1'b1;
            done_next_s  = 1'b1;
            // Same shift state that decides XLAT at index 1, so the two never disagree.
            under_next_s = (sh_next_s != SH_LOADED);
          end else begin
            gclk_next_s = 1'b0;
          end
        end else begin
          hcnt_next_s = hcnt_r + HW'(1);
        end
      end
      GS_BLANK: begin
        gclk_next_s = 1'b0;
        if ((bcnt_r == '0) && (sh_state_r == SH_LOADED)) begin
          xlat_next_s = 1'b1;
        end else begin
          xlat_next_s = 1'b0;
        end
        if (bcnt_r == BC_LAST) begin
          gs_next_s    = GS_RUN;
          bcnt_next_s  = '0;
          hcnt_next_s  = '0;
          edges_next_s = '0;
          blank_next_s = 1'b0;
        end else begin
          bcnt_next_s = bcnt_r + BW'(1);
        end
      end
      default: begin
        gs_next_s    = GS_BLANK;
        bcnt_next_s  = '0;
        gclk_next_s  = 1'b0;
        blank_next_s = 1'b1;
      end
    endcase
  end

  // State and registered pin outputs; reset aborts any partial shift or grayscale period.
  always_ff @(posedge clk) begin
    if (rst) begin
      gs_state_r <= GS_BLANK;
      sh_state_r <= SH_SHIFT;
      hcnt_r     <= '0;
      edges_r    <= '0;
      bcnt_r     <= '0;
      ph_r       <= '0;
      bits_r     <= '0;
      sclk_r     <= 1'b0;
      sin_r      <= 1'b0;
      ready_r    <= 1'b0;
      gclk_r     <= 1'b0;
      blank_r    <= 1'b1;
      xlat_r     <= 1'b0;
      done_r     <= 1'b0;
      under_r    <= 1'b0;
    end else begin
      gs_state_r <= gs_next_s;
      sh_state_r <= sh_next_s;
      hcnt_r     <= hcnt_next_s;
      edges_r    <= edges_next_s;
      bcnt_r     <= bcnt_next_s;
      ph_r       <= ph_next_s;
      bits_r     <= bits_next_s;
      sclk_r     <= sclk_next_s;
      sin_r      <= sin_next_s;
      ready_r    <= ready_next_s;
      gclk_r     <= gclk_next_s;
      blank_r    <= blank_next_s;
      xlat_r     <= xlat_next_s;
      done_r     <= done_next_s;
      under_r    <= under_next_s;
    end
  end

  assign bus.bit_ready = ready_r;
  assign SCLK          = sclk_r;
  assign SIN           = sin_r;
  assign GCLK          = gclk_r;
  assign BLANK         = blank_r;
  assign XLAT          = xlat_r;
  assign frame_done    = done_r;
  assign underrun      = under_r;
endmodule

// File: tb/tb_led_driver_sequencer.sv
// Randomized bench for led_driver_sequencer against a time-arithmetic reference model.
module tb_led_driver_sequencer;
  localparam int SF = 4, GF = 2, GS = 8, SB = 4, BC = 4;
  localparam int HS = SF / 2, HG = GF / 2;
  localparam int RUN_LEN = GS * GF;
  localparam int PER = RUN_LEN + BC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SCLK, SIN, GCLK, BLANK, XLAT, frame_done, underrun;

  led_driver_sequencer_if bus ();

  led_driver_sequencer #(
    .SCLK_FACTOR(SF), .GCLK_FACTOR(GF), .GS_STEPS(GS),
    .SHIFT_BITS(SB), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SCLK(SCLK), .SIN(SIN), .GCLK(GCLK), .BLANK(BLANK), .XLAT(XLAT),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks, failures, n_xlat, n_under;
  // Model state: cycle index since reset release and event times of the shift side.
  int t, ready_from, last_t, loaded_at, nbits;
  bit final_pend, sin_val, xlat_due;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask

  // Blank window index for cycle t, or -1 while the grayscale period runs.
  function automatic int blank_idx(input int tt);
    int pos;
    if (tt < BC) return tt;
    pos = (tt - BC) % PER;
    if (pos >= RUN_LEN) return pos - RUN_LEN;
    return -1;
  endfunction

  function automatic bit gclk_exp(input int tt);
    int pos;
    if (tt < BC) return 1'b0;
    pos = (tt - BC) % PER;
    return (pos < RUN_LEN) && (((pos / HG) % 2) == 1);
  endfunction

  task automatic model_reset();
    t = 0; ready_from = 1; last_t = -100; loaded_at = 0; nbits = 0;
    final_pend = 1'b0; sin_val = 1'b0; xlat_due = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_SCLK", SCLK, 1'b0);
      check("rst_SIN", SIN, 1'b0);
      check("rst_GCLK", GCLK, 1'b0);
      check("rst_BLANK", BLANK, 1'b1);
      check("rst_XLAT", XLAT, 1'b0);
      check("rst_ready", bus.bit_ready, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_underrun", underrun, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: compare outputs of cycle t, then drive inputs and advance the model.
  task automatic step(input int vprob);
    int  idx;
    bit  loaded, er, ex;
    idx    = blank_idx(t);
    loaded = final_pend && (t >= loaded_at);
    er     = (t >= ready_from);
    ex     = (idx == 1) && xlat_due;
    check("bit_ready", bus.bit_ready, er);
    check("SCLK", SCLK, (t >= last_t + HS) && (t < last_t + 2 * HS));
    check("SIN", SIN, sin_val);
    check("BLANK", BLANK, idx >= 0);
    check("GCLK", GCLK, gclk_exp(t));
    check("XLAT", XLAT, ex);
    check("frame_done", frame_done, (t >= BC) && (idx == 0));
    check("underrun", underrun, (t >= BC) && (idx == 0) && !loaded);
    if ((t >= BC) && (idx == 0) && !loaded) n_under++;
    if (idx == 0) xlat_due = loaded;
    if (ex) begin
      final_pend = 1'b0; nbits = 0; ready_from = t + 1; n_xlat++;
    end
    bus.bit_valid = ($urandom_range(99) < vprob);
    bus.bit_data  = 1'($urandom_range(1));
    if (er && bus.bit_valid) begin
      last_t  = t;
      sin_val = bus.bit_data;
      nbits++;
      if (nbits == SB) begin
        final_pend = 1'b1; loaded_at = t + 2 * HS; ready_from = 1 << 30;
      end else begin
        ready_from = t + 2 * HS;
      end
    end
    @(posedge clk); #1;
    t++;
  endtask

  initial begin
    int budget;
    checks = 0; failures = 0; n_xlat = 0; n_under = 0;
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0;
    model_reset();
    apply_reset();
    repeat (300) step(100);
    repeat (600) step(20);
    // Stop the source with three bits shifted, then reset in the middle of the frame.
    budget = 0;
    while (!((nbits == 3) && !final_pend) && (budget < 500)) begin
      step(30);
      budget++;
    end
    check("reach_3_bits", nbits == 3, 1'b1);
    apply_reset();
    repeat (300) step(100);
    check("xlat_seen", n_xlat > 0, 1'b1);
    check("underrun_seen", n_under > 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "simulation time limit");
  end
endmodule
